// File: rtl/multicycle_control.sv
// Multicycle MIPS-style controller: Moore FSM with outputs decoded from the state.
// Optional overflow trap enabled by defining MULTICYCLE_CONTROL_OVF_TRAP_EN.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Overflow,
  output logic       IorD,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       WE3,
  output logic       ALUSrcA,
  output logic       Branch,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       Trap,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUControl,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     r_state;
  state_t     w_dec_state;
  logic       w_funct_ok;
  logic       w_funct_addsub;
  logic [2:0] w_funct_alu;
  logic       w_ovf_trap;

`ifdef MULTICYCLE_CONTROL_OVF_TRAP_EN
  assign w_ovf_trap = Overflow;
`else
  logic w_unused_ovf;
  assign w_unused_ovf = Overflow;
  assign w_ovf_trap   = 1'b0;
`endif

  // Funct decode for R-type execution; unknown Funct falls back to add
  always_comb begin
    w_funct_ok     = 1'b1;
    w_funct_addsub = 1'b0;
    w_funct_alu    = ALU_ADD;
    case (Funct)
      6'b100000: begin w_funct_alu = ALU_ADD; w_funct_addsub = 1'b1; end
      6'b100010: begin w_funct_alu = ALU_SUB; w_funct_addsub = 1'b1; end
      6'b100100: w_funct_alu = ALU_AND;
      6'b100101: w_funct_alu = ALU_OR;
      6'b101010: w_funct_alu = ALU_SLT;
      default: begin
        w_funct_alu = ALU_ADD;
        w_funct_ok  = 1'b0;
      end
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:  r_state <= S_DECODE;
        S_DECODE: begin
          case (Op)
            OP_LW, OP_SW: r_state <= S_MEMADR;
            OP_RTYPE:     r_state <= S_EXECUTE;
            OP_BEQ:       r_state <= S_BRANCH;
            OP_ADDI:      r_state <= S_ADDIEXEC;
            OP_J:         r_state <= S_JUMP;
            default:      r_state <= S_FETCH;
          endcase
        end
        S_MEMADR:   r_state <= (Op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  r_state <= S_MEMWB;
        S_MEMWB:    r_state <= S_FETCH;
        S_MEMWRITE: r_state <= S_FETCH;
        S_EXECUTE: begin
          if (!w_funct_ok)
            r_state <= S_FETCH;
          else if (w_ovf_trap && w_funct_addsub)
            r_state <= S_TRAP;
          else
            r_state <= S_ALUWB;
        end
        S_ALUWB:    r_state <= S_FETCH;
        S_BRANCH:   r_state <= S_FETCH;
        S_ADDIEXEC: r_state <= w_ovf_trap ? S_TRAP : S_ADDIWB;
        S_ADDIWB:   r_state <= S_FETCH;
        S_JUMP:     r_state <= S_FETCH;
`ifdef MULTICYCLE_CONTROL_OVF_TRAP_EN
        S_TRAP:     r_state <= S_TRAP;
`endif
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  // While reset is held the datapath sees the FETCH decode with enables masked
  assign w_dec_state = reset ? r_state : S_FETCH;

  logic       w_iord, w_regdst, w_memtoreg, w_irwrite, w_we3, w_alusrca;
  logic       w_branch, w_pcwrite, w_memwrite, w_trap;
  logic [1:0] w_alusrcb, w_pcsrc;
  logic [2:0] w_aluctl;

  // Moore output decode
  always_comb begin
    w_iord     = 1'b0;
    w_regdst   = 1'b0;
    w_memtoreg = 1'b0;
    w_irwrite  = 1'b0;
    w_we3      = 1'b0;
    w_alusrca  = 1'b0;
    w_branch   = 1'b0;
    w_pcwrite  = 1'b0;
    w_memwrite = 1'b0;
    w_trap     = 1'b0;
    w_alusrcb  = 2'b00;
    w_pcsrc    = 2'b00;
    w_aluctl   = 3'b000;
    case (w_dec_state)
      S_FETCH: begin
        w_alusrcb = 2'b01;
        w_aluctl  = ALU_ADD;
        w_irwrite = 1'b1;
        w_pcwrite = 1'b1;
      end
      S_DECODE: begin
        w_alusrcb = 2'b11;
        w_aluctl  = ALU_ADD;
      end
      S_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_aluctl  = ALU_ADD;
      end
      S_MEMREAD: w_iord = 1'b1;
      S_MEMWB: begin
        w_memtoreg = 1'b1;
        w_we3      = 1'b1;
      end
      S_MEMWRITE: begin
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
      end
      S_EXECUTE: begin
        w_alusrca = 1'b1;
        w_aluctl  = w_funct_alu;
      end
      S_ALUWB: begin
        w_regdst = 1'b1;
        w_we3    = 1'b1;
      end
      S_BRANCH: begin
        w_alusrca = 1'b1;
        w_aluctl  = ALU_SUB;
        w_pcsrc   = 2'b01;
        w_branch  = 1'b1;
      end
      S_ADDIEXEC: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_aluctl  = ALU_ADD;
      end
      S_ADDIWB: w_we3 = 1'b1;
      S_JUMP: begin
        w_pcsrc   = 2'b10;
        w_pcwrite = 1'b1;
      end
`ifdef MULTICYCLE_CONTROL_OVF_TRAP_EN
      S_TRAP: w_trap = 1'b1;
`endif
      default: w_trap = 1'b0;
    endcase
  end

  assign IorD       = w_iord;
  assign RegDst     = w_regdst;
  assign MemtoReg   = w_memtoreg;
  assign ALUSrcA    = w_alusrca;
  assign ALUSrcB    = w_alusrcb;
  assign PCSrc      = w_pcsrc;
  assign ALUControl = w_aluctl;
  assign IRWrite    = w_irwrite  & reset;
  assign WE3        = w_we3      & reset;
  assign Branch     = w_branch   & reset;
  assign PCWrite    = w_pcwrite  & reset;
  assign MemWrite   = w_memwrite & reset;
  assign Trap       = w_trap     & reset;
  assign State      = r_state;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset: clk  in  1  rising-edge clock; reset  in  1  synchronous active-low reset.
REQ-002 SHALL have the status inputs: Op  in  6  IR[31:26]; Funct  in  6  IR[5:0]; Overflow  in  1  combinational ALU overflow.
REQ-003 SHALL have the 1-bit outputs IorD, RegDst, MemtoReg, IRWrite, WE3, ALUSrcA, Branch, PCWrite, MemWrite, Trap; meanings match the datapath controls of the same names, MemWrite is the memory write strobe and Trap is the overflow-fault flag.
REQ-004 SHALL have the outputs: ALUSrcB  out  2  SrcB select; PCSrc  out  2  next-PC select; ALUControl  out  3  ALU operation; State  out  4  current state encoding, for debug.

Function
REQ-005 SHALL be a Moore FSM, one state register, with outputs decoded combinationally from State; in EXECUTE, ALUControl additionally decodes Funct.
REQ-006 SHALL use these state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11, TRAP=12; any other encoding SHALL go to FETCH on the next edge.
REQ-007 SHALL use these opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
REQ-008 SHALL use these ALUControl codes: add 010, sub 110, and 000, or 001, slt 111.
REQ-009 SHALL map Funct in EXECUTE: 100000 to add, 100010 to sub, 100100 to and, 100101 to or, 101010 to slt; any other Funct gives add.
REQ-010 SHALL drive every output not listed for a state as 0, including ALUControl=000.
REQ-011 SHALL drive FETCH as IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=010, PCSrc=00, IRWrite=1, PCWrite=1; next state is DECODE.
REQ-012 SHALL drive DECODE as ALUSrcA=0, ALUSrcB=11, ALUControl=010; next state: lw/sw to MEMADR, R-type to EXECUTE, beq to BRANCH, addi to ADDIEXEC, j to JUMP, any other Op to FETCH (no-op, 2 cycles).
REQ-013 SHALL drive MEMADR as ALUSrcA=1, ALUSrcB=10, ALUControl=010; next state is MEMREAD for lw and MEMWRITE for sw.
REQ-014 SHALL drive MEMREAD as IorD=1, next MEMWB; MEMWB as RegDst=0, MemtoReg=1, WE3=1, next FETCH; MEMWRITE as IorD=1, MemWrite=1, next FETCH.
REQ-015 SHALL drive EXECUTE as ALUSrcA=1, ALUSrcB=00, ALUControl per REQ-009; next state is ALUWB for a recognised Funct and FETCH otherwise (no register write).
REQ-016 SHALL drive ALUWB as RegDst=1, MemtoReg=0, WE3=1; next state is FETCH.
REQ-017 SHALL drive BRANCH as ALUSrcA=1, ALUSrcB=00, ALUControl=110, PCSrc=01, Branch=1; next state is FETCH.
REQ-018 SHALL drive ADDIEXEC as ALUSrcA=1, ALUSrcB=10, ALUControl=010, next ADDIWB; ADDIWB as RegDst=0, MemtoReg=0, WE3=1, next FETCH.
REQ-019 SHALL drive JUMP as PCSrc=10, PCWrite=1; next state is FETCH.
REQ-020 SHALL give these instruction latencies in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.

Reset
REQ-021 SHALL load State=FETCH on any rising clk edge where reset=0, overriding every transition, including mid-instruction and while in TRAP.
REQ-022 SHALL force PCWrite, IRWrite, WE3, MemWrite, Branch and Trap to 0 combinationally while reset=0; all other outputs follow the FETCH decode.
REQ-023 SHALL make its first cycle after reset deassertion a full FETCH.

Configuration
REQ-024 SHALL take its overflow trap from the macro MULTICYCLE_CONTROL_OVF_TRAP_EN.
REQ-025 SHALL, when the macro is defined, go from EXECUTE (Funct add/sub only) or ADDIEXEC to TRAP instead of the writeback state if Overflow=1 in that cycle.
REQ-026 SHALL, in TRAP, drive Trap=1 with all enables 0 and hold TRAP until reset.
REQ-027 SHALL, when the macro is undefined, ignore Overflow, never enter TRAP, tie Trap to 0, and treat encoding 12 as illegal per REQ-006.

Verification
REQ-028 SHALL be covered by a reset test: hold reset=0 for 3 edges from MEMREAD -> State=0, PCWrite=IRWrite=WE3=MemWrite=0 during reset, first released cycle has PCWrite=1 and IRWrite=1.
REQ-029 SHALL be covered by an lw test: Op=100011 -> State sequence 0,1,2,3,4,0; WE3=1 and MemtoReg=1 only in state 4.
REQ-030 SHALL be covered by an R-type test: Op=000000, Funct=101010 -> EXECUTE gives ALUControl=111, then ALUWB with RegDst=1; Funct=000111 -> 0,1,6,0 with WE3 never 1.
REQ-031 SHALL be covered by a beq/j test: Op=000100 -> BRANCH gives Branch=1, PCSrc=01, ALUControl=110; Op=000010 -> JUMP gives PCWrite=1, PCSrc=10; both return to FETCH.
REQ-032 SHALL be covered by an illegal-Op test: Op=111111 -> 0,1,0, no write enables asserted.
REQ-033 SHALL be covered by an overflow test: addi with Overflow=1 in ADDIEXEC -> with macro, State=12 and Trap=1 until reset; without macro, ADDIWB then FETCH.
